// File: rtl/calc_pkg.sv
// Shared calculator types: button vector layout, B_* key codes, arbiter state and grant priority.
// Bit i of buttons_t is button index i; num_0 is bit 0 and clear is the MSB.
package calc_pkg;

  typedef struct packed {
    logic clear;
    logic mem_recall;
    logic mem_clear;
    logic mem_sub;
    logic mem_add;
    logic op_percent;
    logic op_sqrt;
    logic op_div;
    logic op_mul;
    logic op_sub;
    logic op_add;
    logic op_eq;
    logic dot;
    logic num_9;
    logic num_8;
    logic num_7;
    logic num_6;
    logic num_5;
    logic num_4;
    logic num_3;
    logic num_2;
    logic num_1;
    logic num_0;
  } buttons_t;

  localparam int NumButtons = $bits(buttons_t);
  localparam int ButtonIdxW = $clog2(NumButtons);
  localparam int IdxClear   = 22;

  localparam logic [15:0] B_NONE       = 16'h0000;
  localparam logic [15:0] B_NUM_0      = 16'h0030;
  localparam logic [15:0] B_NUM_1      = 16'h0031;
  localparam logic [15:0] B_NUM_2      = 16'h0032;
  localparam logic [15:0] B_NUM_3      = 16'h0033;
  localparam logic [15:0] B_NUM_4      = 16'h0034;
  localparam logic [15:0] B_NUM_5      = 16'h0035;
  localparam logic [15:0] B_NUM_6      = 16'h0036;
  localparam logic [15:0] B_NUM_7      = 16'h0037;
  localparam logic [15:0] B_NUM_8      = 16'h0038;
  localparam logic [15:0] B_NUM_9      = 16'h0039;
  localparam logic [15:0] B_DOT        = 16'h002E;
  localparam logic [15:0] B_OP_EQ      = 16'h003D;
  localparam logic [15:0] B_OP_ADD     = 16'h002B;
  localparam logic [15:0] B_OP_SUB     = 16'h002D;
  localparam logic [15:0] B_OP_MUL     = 16'h002A;
  localparam logic [15:0] B_OP_DIV     = 16'h002F;
  localparam logic [15:0] B_OP_SQRT    = 16'h0072;
  localparam logic [15:0] B_OP_PERCENT = 16'h0025;
  localparam logic [15:0] B_MEM_ADD    = 16'h0101;
  localparam logic [15:0] B_MEM_SUB    = 16'h0102;
  localparam logic [15:0] B_MEM_CLEAR  = 16'h0103;
  localparam logic [15:0] B_MEM_RECALL = 16'h0104;
  localparam logic [15:0] B_CLEAR      = 16'h0043;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Button indices, highest priority first; digits run 1..9 then 0.
  localparam logic [ButtonIdxW-1:0] PrioOrder [NumButtons] = '{
    5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd16, 5'd15,
    5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
    5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,  5'd8,  5'd9,
    5'd0
  };

  function automatic logic [15:0] button_code(input logic [ButtonIdxW-1:0] idx);
    logic [15:0] code;
    case (idx)
      5'd0:    code = B_NUM_0;
      5'd1:    code = B_NUM_1;
      5'd2:    code = B_NUM_2;
      5'd3:    code = B_NUM_3;
      5'd4:    code = B_NUM_4;
      5'd5:    code = B_NUM_5;
      5'd6:    code = B_NUM_6;
      5'd7:    code = B_NUM_7;
      5'd8:    code = B_NUM_8;
      5'd9:    code = B_NUM_9;
      5'd10:   code = B_DOT;
      5'd11:   code = B_OP_EQ;
      5'd12:   code = B_OP_ADD;
      5'd13:   code = B_OP_SUB;
      5'd14:   code = B_OP_MUL;
      5'd15:   code = B_OP_DIV;
      5'd16:   code = B_OP_SQRT;
      5'd17:   code = B_OP_PERCENT;
      5'd18:   code = B_MEM_ADD;
      5'd19:   code = B_MEM_SUB;
      5'd20:   code = B_MEM_CLEAR;
      5'd21:   code = B_MEM_RECALL;
      5'd22:   code = B_CLEAR;
      default: code = B_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debounces one raw button level; stable_o flips after DEBOUNCE_CYCLES consecutive differing samples.
// press_o pulses for one cycle, registered together with the 0->1 flip of stable_o; no backpressure.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any sample matching the stable level restarts the run, so bounce never accumulates.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (raw_i != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = raw_i;
        press_d  = raw_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/button_arbiter.sv
// Debounces all switches, queues each press as a pending bit and replays them one at a time as press/gap.
// Press reaches buttons_o DEBOUNCE_CYCLES+2 edges after the raw rise when idle; repeats while pending are dropped and flagged.
module button_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned PRESS_CYCLES    = 2,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  buttons_t    buttons_raw_i,
  output buttons_t    buttons_o,
  output logic [15:0] active_code_o,
  output logic        busy_o,
  output logic        dropped_o
);

  localparam int unsigned MaxCycles = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] PressLast = CntW'(PRESS_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);
  localparam logic [NumButtons-1:0] ClearOnly = NumButtons'(1) << IdxClear;

  logic [NumButtons-1:0] raw_vec;
  logic [NumButtons-1:0] press_vec;
  logic [NumButtons-1:0] unused_stable_vec;

  assign raw_vec = buttons_raw_i;

  for (genvar gi = 0; gi < NumButtons; gi++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .raw_i   (raw_vec[gi]),
      .stable_o(unused_stable_vec[gi]),
      .press_o (press_vec[gi])
    );
  end

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NumButtons-1:0] pending_q, pending_d;
  logic [NumButtons-1:0] buttons_q, buttons_d;
  logic [15:0]           code_q, code_d;
  logic                  busy_q, busy_d;
  logic                  dropped_q, dropped_d;

  logic                  win_found;
  logic [ButtonIdxW-1:0] win_idx;
  logic [NumButtons-1:0] win_onehot;
  logic                  grant;
  logic [NumButtons-1:0] grant_mask;
  logic [NumButtons-1:0] dropped_vec;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NumButtons; i++) begin
      if (!win_found && pending_q[PrioOrder[i[ButtonIdxW-1:0]]]) begin
        win_found = 1'b1;
        win_idx   = PrioOrder[i[ButtonIdxW-1:0]];
      end
    end
    win_onehot = NumButtons'(1) << win_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      buttons_q <= '0;
      code_q    <= B_NONE;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      buttons_q <= buttons_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending_q)         state_d = PRESS;
      PRESS:   if (cnt_q == PressLast) state_d = GAP;
      GAP:     if (cnt_q == GapLast)   state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
    // Counter restarts on every state change and rests at zero in IDLE.
    if ((state_d == state_q) && (state_q != IDLE)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    grant      = (state_q == IDLE) && (state_d == PRESS);
    grant_mask = grant ? win_onehot : '0;
    buttons_d  = buttons_q;
    code_d     = code_q;
    if (grant) begin
      buttons_d = win_onehot;
      code_d    = button_code(win_idx);
    end else if ((state_q == PRESS) && (state_d == GAP)) begin
      buttons_d = '0;
      code_d    = B_NONE;
    end

    // A new press of the button being granted re-queues it, so it is not a drop.
    dropped_vec = press_vec & pending_q & ~grant_mask;
    if (press_vec[IdxClear]) begin
      pending_d = ClearOnly;
      dropped_d = dropped_vec[IdxClear];
    end else begin
      pending_d = (pending_q & ~grant_mask) | press_vec;
      dropped_d = |dropped_vec;
    end

    busy_d = (state_d != IDLE);
  end

  assign buttons_o     = buttons_q;
  assign active_code_o = code_q;
  assign busy_o        = busy_q;
  assign dropped_o     = dropped_q;

endmodule

// File: doc/button_arbiter.md
# button_arbiter

- Sits between the board switches and `calculator`, in the divided 1 kHz clock domain.
- Debounces each raw button level and turns every debounced press into a queued, one-shot request.
- Replays pending requests to the calculator one at a time, as a clean press/release sequence.
- Simultaneous switch activity never presents two buttons to the calculator at once, and a press is never merged or lost silently.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 20: consecutive cycles a raw level must differ from the debounced state before it is accepted; must be ≥1.
- `PRESS_CYCLES`, default 2: cycles a granted button is held asserted on `buttons_o`; must be ≥1.
- `GAP_CYCLES`, default 2: all-zero cycles after each press, before the next grant; must be ≥1.

Ports:
- `clk_i`, input, 1: clock; one clock domain only.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `buttons_raw_i`, input, `calc_pkg::buttons_t`: raw, possibly bouncing, button levels.
- `buttons_o`, output, `calc_pkg::buttons_t`: zero or one-hot button presented to `calculator`.
- `active_code_o`, output, 16: `calc_pkg::B_*` code of the button currently on `buttons_o`; `B_NONE` otherwise.
- `busy_o`, output, 1: FSM is not in IDLE.
- `dropped_o`, output, 1: one-cycle pulse when a press arrives for a button that is already pending.

## Operation

- **Debounce, per button:**
  - Stable bit `s` and counter `c`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Each edge with raw == `s`: `c` ← 0.
  - Each edge with raw ≠ `s`: if `c == DEBOUNCE_CYCLES-1`, then `s` ← raw and `c` ← 0; else `c` ← `c+1`.
  - A 0→1 transition of `s` is a press event. Release events are ignored.
- **Pending vector** (`NumButtons` bits):
  - A press event sets the button's bit at the following edge.
  - If the bit is already set, it stays set and `dropped_o` pulses for one cycle.
  - A press of `clear` sets the `clear` bit and flushes every other pending bit on the same edge; `dropped_o` does not pulse for flushed bits.
- **Arbitration:** fixed priority, highest first: `clear`, `mem_recall`, `mem_clear`, `mem_sub`, `mem_add`, `op_percent`, `op_sqrt`, `op_div`, `op_mul`, `op_sub`, `op_add`, `op_eq`, `dot`, `num_1` … `num_9`, `num_0`.
- **FSM** (`arb_state_e`: IDLE, PRESS, GAP):
  - IDLE → PRESS when pending ≠ 0. On that edge:
    - latch the winner's one-hot vector into `buttons_o` and its code into `active_code_o`;
    - clear the winner's pending bit;
    - load a cycle counter.
  - PRESS → GAP after `PRESS_CYCLES` cycles in PRESS; `buttons_o` ← 0 and `active_code_o` ← `B_NONE` on that edge.
  - GAP → IDLE after `GAP_CYCLES` cycles.
- **Simultaneous events:**
  - A press event for the button being granted on the same edge leaves its pending bit set; the set wins over the grant clear.
  - Presses arriving during PRESS or GAP only queue.
- All outputs are registered; `busy_o` is registered from the next state.

## Timing

- Reset values: `buttons_o` = 0, `active_code_o` = `B_NONE`, `busy_o` = 0, `dropped_o` = 0, all `s`/`c`/pending = 0, state = IDLE.
- Reset asserted mid-press: outputs return to reset values immediately, without waiting for a clock. The in-flight press and all pending presses are discarded.
- A switch held high through reset yields one press event `DEBOUNCE_CYCLES` edges after release of reset.
- Latency, with the first edge sampling a new raw level numbered 1:
  - `s` flips at edge D (= `DEBOUNCE_CYCLES`);
  - the pending bit sets at edge D+1;
  - `buttons_o` is asserted at edge D+2 when idle.
- Each grant occupies exactly `PRESS_CYCLES` + `GAP_CYCLES` cycles.
- The next grant is issued on the edge after GAP ends, since IDLE lasts one cycle.
- Bounce shorter than D consecutive cycles never changes `s`.

## Structure

- `calc_pkg` gains:
  - `NumButtons`;
  - `arb_state_e`;
  - a function mapping a button index to its `B_*` code;
  - the priority order as an index constant.
- The existing `buttons_t` and `B_*` codes are reused.
- Sub-module `button_debouncer`: one bit plus its counter, outputs `s` and a press pulse, with the same clock/reset ports. It is instantiated `NumButtons` times through generate.
- The top level replaces its direct switch→buttons assignment with this block.

## Test plan

Use D=4, PRESS=2, GAP=2 unless noted.

1. Reset, then a clean `num_5` rise before edge 1 → `buttons_o.num_5` = 1 for edges 6–7, 0 from edge 8. `active_code_o` = `B_NUM_5` during the press. `busy_o` drops after edge 10.
2. `num_3` toggling every cycle for 10 cycles, then low → no press, `s` never 1. With D=4, a 3-cycle-high glitch also produces no press.
3. `num_1`, `op_add` and `dot` rise on the same cycle → grants in the order `op_add`, `dot`, `num_1`. Each is 2 cycles high, separated by exactly 3 zero cycles (GAP plus IDLE).
4. `num_2` pressed, released and pressed again while it is still pending → `dropped_o` pulses once and only one `num_2` grant is issued.
5. `num_7` and `num_8` pending, then `clear` is pressed → only `clear` is granted afterwards; pending = 0; `dropped_o` stays 0.
6. `rst_ni` pulled low during PRESS → `buttons_o` = 0 with no clock edge. After release, no stale grant appears.
